point_output_streamer: RTL and testbench

- Sits directly downstream of the affine reduction stage.
- Captures the final affine point (x, y) when that stage pulses its finished flag.
- Forces both coordinates into canonical range [0, P-1].
- Streams the point out over a narrow valid/ready word bus to the chip output interface: x first, then y.

---
 rtl/point_output_streamer.sv | 135 +++++++++++++
 tb/tb_point_output_streamer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/point_output_streamer.sv
// Captures a finished affine point, reduces both coordinates into [0, P-1] and
// streams them out x-then-y, least-significant word first, over a valid/ready bus.
module point_output_streamer #(
  parameter int             WORD_W = 64,
  parameter logic [254:0]   P      = {255{1'b1}} - 255'd18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [254:0]      i_x,
  input  logic [254:0]      i_y,
  output logic              o_busy,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_last,
  output logic              o_overflow
);

  localparam int N_WORDS = 256 / WORD_W;
  localparam int IDX_W   = $clog2(2 * N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CANON  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t             state_r, next_state_s;
  logic [254:0]       x_r, y_r, x_nxt_s, y_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic               ovf_r, ovf_nxt_s;
  logic               hs_s, last_s;
  logic [511:0]       ext_s;
  logic [WORD_W-1:0]  words_s [2*N_WORDS];

  // A borrow out of the 256-bit subtraction means v < P; inputs are below 2P,
  // so a single conditional subtract lands in canonical range.
  function automatic logic [254:0] canon(input logic [254:0] v);
    logic [255:0] diff;
    diff = {1'b0, v} - {1'b0, P};
    return diff[255] ? v : diff[254:0];
  endfunction

  assign ext_s = {1'b0, y_r, 1'b0, x_r};

  for (genvar k = 0; k < 2 * N_WORDS; k++) begin : g_word
    assign words_s[k] = ext_s[k*WORD_W +: WORD_W];
  end

  // Outputs decode from registered state only; no input-to-output path.
  assign o_valid    = (state_r == ST_STREAM);
  assign last_s     = (idx_r == LAST_IDX);
  assign o_last     = o_valid & last_s;
  assign o_data     = o_valid ? words_s[idx_r] : {WORD_W{1'b0}};
  assign o_busy     = (state_r != ST_IDLE);
  assign o_overflow = ovf_r;
  assign hs_s       = o_valid & i_ready;

  // Next-state, capture, canonicalisation and overflow decisions.
  always_comb begin
    next_state_s = state_r;
    x_nxt_s      = x_r;
    y_nxt_s      = y_r;
    idx_nxt_s    = idx_r;
    ovf_nxt_s    = ovf_r;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          x_nxt_s      = i_x;
          y_nxt_s      = i_y;
          next_state_s = ST_CANON;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CANON: begin
        x_nxt_s      = canon(x_r);
        y_nxt_s      = canon(y_r);
        idx_nxt_s    = {IDX_W{1'b0}};
        next_state_s = ST_STREAM;
        if (i_valid) begin
          ovf_nxt_s = 1'b1;
        end else begin
          ovf_nxt_s = ovf_r;
        end
      end
      ST_STREAM: begin
        if (hs_s && last_s) begin
          // A point offered on the final handshake is taken, not dropped.
          if (i_valid) begin
            x_nxt_s      = i_x;
            y_nxt_s      = i_y;
            next_state_s = ST_CANON;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          if (i_valid) begin
            ovf_nxt_s = 1'b1;
          end else begin
            ovf_nxt_s = ovf_r;
          end
          if (hs_s) begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end else begin
            idx_nxt_s = idx_r;
          end
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      x_r     <= '0;
      y_r     <= '0;
      idx_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      idx_r   <= idx_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

endmodule

// File: tb/tb_point_output_streamer.sv
// Scoreboard bench: the driver models acceptance and queues expected words,
// a negedge monitor compares every presented word and the status outputs.
module tb_point_output_streamer;

  localparam int W = 64;
  localparam int N = 256 / W;
  localparam logic [255:0] PF = (256'd1 << 255) - 256'd19;

  logic          clk;
  logic          i_rst_n, i_valid, i_ready;
  logic [254:0]  i_x, i_y;
  logic          o_busy, o_valid, o_last, o_overflow;
  logic [W-1:0]  o_data;

  point_output_streamer #(.WORD_W(W)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_x(i_x), .i_y(i_y),
    .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_last(o_last), .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; bit last; } word_t;
  word_t exp_q[$];

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 0;
  bit  exp_valid = 0, exp_busy = 0, exp_ovf = 0;
  int  m_left = 0;
  bit  m_canon = 0, m_ovf = 0, flush_pend = 0;

  task automatic check(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [255:0] ref_canon(input logic [254:0] v);
    logic [255:0] e;
    e = {1'b0, v};
    return (e >= PF) ? e - PF : e;
  endfunction

  task automatic push_point(input logic [254:0] x, input logic [254:0] y);
    logic [511:0] ext;
    word_t w;
    ext = {ref_canon(y), ref_canon(x)};
    for (int k = 0; k < 2 * N; k++) begin
      w.d = ext[k*W +: W];
      w.last = (k == 2 * N - 1);
      exp_q.push_back(w);
    end
  endtask

  // One clock of stimulus; the model tracks words still owed and the canon cycle.
  task automatic step(input bit v, input logic [254:0] x, input logic [254:0] y,
                      input bit rdy, input bit rst);
    bit hs, accept;
    @(posedge clk); #1;
    if (flush_pend) begin
      exp_q.delete();
      flush_pend = 0;
    end
    i_rst_n = !rst;
    i_valid = v;
    i_x = x;
    i_y = y;
    i_ready = rst ? 1'b0 : rdy;
    exp_valid = (m_left > 0) && !m_canon;
    exp_busy  = (m_left > 0);
    exp_ovf   = m_ovf;
    hs = exp_valid && i_ready;
    if (rst) begin
      m_left = 0; m_canon = 0; m_ovf = 0; flush_pend = 1;
    end else begin
      accept = v && ((m_left == 0) || (hs && m_left == 1));
      if (m_canon) m_canon = 0;
      else if (hs) m_left--;
      if (v && !accept) m_ovf = 1;
      if (accept) begin
        m_left = 2 * N;
        m_canon = 1;
        push_point(x, y);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic [254:0] rand_coord();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return r[254:0];
      1: return PF[254:0] + 255'($urandom_range(0, 18));
      2: return PF[254:0] - 255'($urandom_range(1, 5));
      default: return 255'($urandom_range(0, 1000));
    endcase
  endfunction

  // Monitor: compare the presented word against the queue head, pop on handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_word", 256'(o_data), 256'd0);
        end else begin
          check(o_data == exp_q[0].d, "data", 256'(o_data), 256'(exp_q[0].d));
          check(o_last == exp_q[0].last, "last", 256'(o_last), 256'(exp_q[0].last));
          if (i_ready) void'(exp_q.pop_front());
        end
      end else begin
        check(o_data == '0, "data_idle_zero", 256'(o_data), 256'd0);
        check(o_last == 1'b0, "last_idle_zero", 256'(o_last), 256'd0);
      end
      check(o_valid == exp_valid, "valid", 256'(o_valid), 256'(exp_valid));
      check(o_busy == exp_busy, "busy", 256'(o_busy), 256'(exp_busy));
      check(o_overflow == exp_ovf, "overflow", 256'(o_overflow), 256'(exp_ovf));
    end
  end

  initial begin
    logic [254:0] all_ones;
    logic [254:0] p255;
    all_ones = {255{1'b1}};
    p255 = PF[254:0];
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_x = '0; i_y = '0;
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk_en = 1;
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(2);

    // basic point
    step(1'b1, 255'd1, 255'd2, 1'b1, 1'b0);
    idle(10);
    // canonicalisation
    step(1'b1, p255 + 255'd5, p255, 1'b1, 1'b0);
    idle(10);
    step(1'b1, all_ones, p255 - 255'd1, 1'b1, 1'b0);
    idle(10);
    // backpressure
    begin
      bit pat [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      step(1'b1, 255'hAB, 255'd0, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, '0, pat[i], 1'b0);
      idle(5);
    end
    // overflow during word 3 of x
    step(1'b1, 255'd7, 255'd70, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 255'h55, 255'h66, 1'b1, 1'b0);
    idle(8);
    // new point on the last-word handshake
    step(1'b1, 255'd3, 255'd4, 1'b1, 1'b0);
    idle(8);
    step(1'b1, 255'd9, 255'd10, 1'b1, 1'b0);
    idle(12);
    // reset mid-stream after word 2
    step(1'b1, 255'h77, 255'h88, 1'b1, 1'b0);
    idle(4);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 255'h31, 255'h32, 1'b1, 1'b0);
    idle(10);

    // randomized traffic with backpressure, collisions and rare resets
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 5) == 0, rand_coord(), rand_coord(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    idle(30);
    check(exp_q.size() == 0, "queue_drained", 256'(exp_q.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
